npu_mac_sequencer: RTL and testbench
====================================

Name: npu_mac_sequencer

Overview:
Host-programmable sequencer that time-shares one MULT unit and one ACTI unit to compute a dot product of length LEN, then applies the activation: result = ACTI(sum over i of MULT(W[i], X[i])). The host fills on-chip W/X vector buffers over the Avalon-MM slave, writes START, then polls STATUS and reads RESULT. MULT and ACTI are instantiated outside this block and connected through the mult_*/acti_* ports.

Parameters:
DEPTH, 16, number of entries in each of the W and X buffers (power of 2)
PTR_W, 4, log2(DEPTH)
DATA_W, 32, operand, accumulator and result width

Ports:
clk  in  1  Avalon clock
rst  in  1  reset, asynchronous, active-high
addr  in  3  register select
wdata  in  DATA_W  write data
rdata  out  DATA_W  read data, registered
cs  in  1  chip select
read  in  1  read strobe
write  in  1  write strobe
mult_w  out  DATA_W  registered weight operand to MULT
mult_x  out  DATA_W  registered input operand to MULT
mult_out  in  DATA_W  MULT result, combinational from mult_w/mult_x
acti_in  out  DATA_W  accumulator value to ACTI (acc register driven directly)
acti_out  in  DATA_W  ACTI result, combinational from acti_in

Behaviour:
- Clock is clk. Reset is rst: asynchronous, active-high. While rst is high, all registers clear and the FSM returns to IDLE immediately, including mid-run.
- Reset values: rdata=0, mult_w=0, mult_x=0, acc=0, result=0, w_ptr=0, x_ptr=0, idx=0, busy=0, done=0, err=0, LEN=DEPTH.
- Register map. An access requires cs & write or cs & read:
  - 0 W_DATA (write): W[w_ptr] <= wdata, then w_ptr++.
  - 1 X_DATA (write): X[x_ptr] <= wdata, then x_ptr++.
  - 2 RESULT (read).
  - 3 CTRL (write): bit0 START, bit1 CLEAR. CLEAR zeroes w_ptr, x_ptr, err and done.
  - 4 LEN (read/write): low PTR_W+1 bits.
  - 5 STATUS (read): bit0 busy, bit1 done, bit2 err, bits[15:8] w_ptr, bits[23:16] x_ptr.
  - Unmapped reads return 0. Unmapped writes are ignored.
- Reads: rdata is updated on the clock edge after cs & read, so data has 1-cycle latency. rdata holds its value otherwise.
- FSM states: IDLE, FETCH, MAC, ACT.
  - IDLE: a START write with 1 <= LEN <= DEPTH clears acc and idx, clears done, sets busy, and moves to FETCH.
  - FETCH: mult_w <= W[idx], mult_x <= X[idx]; next state MAC.
  - MAC: acc <= acc + mult_out, modulo 2^DATA_W with two's-complement wrap and no saturation. If idx == LEN-1, go to ACT; otherwise idx++ and go to FETCH.
  - ACT: result <= acti_out; busy <= 0; done <= 1; go to IDLE.
- Latency: START accepted at edge E0. done=1 and RESULT is valid after edge E0 + 2*LEN + 1.
- Boundary conditions:
  - START with LEN=0 or LEN>DEPTH: ignored, err <= 1.
  - START while busy: ignored, err <= 1, the run continues unaffected.
  - W_DATA or X_DATA write while busy: ignored, err <= 1.
  - LEN write while busy: ignored, err <= 1.
  - W_DATA write with w_ptr==DEPTH: dropped, err <= 1, pointer saturates at DEPTH. X_DATA follows the same rule.
  - START and CLEAR in the same write: CLEAR takes effect first, then START is evaluated.
  - err is sticky until CLEAR or reset.
  - Buffers are not cleared by CLEAR or reset; only the pointers are.
  - Pointers are not auto-reset by START, so the host must CLEAR before reloading.
  - RESULT keeps its last value until the next ACT.

Test Plan:
Bench models MULT as the low 32 bits of the signed product and ACTI as ReLU.
- Basic: CLEAR; W=1,2,3,4; X=5,6,7,8; LEN=4; START -> busy next cycle; done=1 after E0+9; RESULT reads 70 one cycle after the read strobe.
- Activation clamp: CLEAR; W=-3; X=2; LEN=1; START -> done after E0+3; RESULT=0; acti_in observed as 0xFFFFFFFA during ACT.
- Wrap: CLEAR; W=0x7FFFFFFF,0x7FFFFFFF; X=1,1; LEN=2 -> acc wraps to 0xFFFFFFFE; RESULT=0 (ReLU of a negative value); err=0.
- Protocol errors (each followed by CLEAR):
  - LEN=0 then START -> busy stays 0, STATUS bit2=1.
  - LEN=17 then START -> busy stays 0, STATUS bit2=1.
  - During a LEN=4 run, write W_DATA and START -> err=1, RESULT still 70 for the basic-case data.
  - Write 17 W entries -> w_ptr=16, err=1.
- Reset mid-run: assert rst asynchronously during the MAC state of a LEN=4 run -> all outputs 0 at once, STATUS=0, LEN=16 after release; with pointers reloaded via CLEAR, START reproduces 70.

Source files
------------

// File: rtl/npu_mac_sequencer.sv
// Avalon-MM programmable dot-product sequencer: shares one external MULT and one
// external ACTI unit across LEN element pairs, then activates the accumulated sum.
module npu_mac_sequencer #(
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    input  logic              cs,
    input  logic              read,
    input  logic              write,
    output logic [DATA_W-1:0] mult_w,
    output logic [DATA_W-1:0] mult_x,
    input  logic [DATA_W-1:0] mult_out,
    output logic [DATA_W-1:0] acti_in,
    input  logic [DATA_W-1:0] acti_out
);

    localparam logic [2:0] A_WDATA  = 3'd0;
    localparam logic [2:0] A_XDATA  = 3'd1;
    localparam logic [2:0] A_RESULT = 3'd2;
    localparam logic [2:0] A_CTRL   = 3'd3;
    localparam logic [2:0] A_LEN    = 3'd4;
    localparam logic [2:0] A_STATUS = 3'd5;

    localparam logic [PTR_W:0]   DEPTH_P = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   ONE_P   = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] ONE_I   = PTR_W'(1);

    typedef enum logic [1:0] {IDLE, FETCH, MAC, ACT} state_t;

    state_t              state_q, state_d;
    logic [PTR_W:0]      w_ptr_q, w_ptr_d;
    logic [PTR_W:0]      x_ptr_q, x_ptr_d;
    logic [PTR_W:0]      len_q, len_d;
    logic [PTR_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [DATA_W-1:0]   mult_w_q, mult_w_d;
    logic [DATA_W-1:0]   mult_x_q, mult_x_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   w_mem [DEPTH];
    logic [DATA_W-1:0]   x_mem [DEPTH];
    logic                w_we, x_we, start_go;
    logic                wr, rd;
    logic [DATA_W-1:0]   status;

    assign wr = cs & write;
    assign rd = cs & read;

    assign rdata   = rdata_q;
    assign mult_w  = mult_w_q;
    assign mult_x  = mult_x_q;
    assign acti_in = acc_q;

    always_comb begin
        status        = '0;
        status[0]     = busy_q;
        status[1]     = done_q;
        status[2]     = err_q;
        status[15:8]  = 8'(w_ptr_q);
        status[23:16] = 8'(x_ptr_q);
    end

    // Host register writes are resolved first; the FSM case below may then
    // override done/busy, so an ACT cycle always reports completion.
    always_comb begin
        state_d  = state_q;
        w_ptr_d  = w_ptr_q;
        x_ptr_d  = x_ptr_q;
        len_d    = len_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        result_d = result_q;
        mult_w_d = mult_w_q;
        mult_x_d = mult_x_q;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
        w_we     = 1'b0;
        x_we     = 1'b0;
        start_go = 1'b0;

        if (wr) begin
            case (addr)
                A_WDATA: begin
                    if (busy_q || w_ptr_q == DEPTH_P) begin
                        err_d = 1'b1;
                    end else begin
                        w_we    = 1'b1;
                        w_ptr_d = w_ptr_q + ONE_P;
                    end
                end
                A_XDATA: begin
                    if (busy_q || x_ptr_q == DEPTH_P) begin
                        err_d = 1'b1;
                    end else begin
                        x_we    = 1'b1;
                        x_ptr_d = x_ptr_q + ONE_P;
                    end
                end
                A_CTRL: begin
                    if (wdata[1]) begin
                        w_ptr_d = '0;
                        x_ptr_d = '0;
                        err_d   = 1'b0;
                        done_d  = 1'b0;
                    end
                    if (wdata[0]) begin
                        if (busy_q || len_q == '0 || len_q > DEPTH_P) begin
                            err_d = 1'b1;
                        end else begin
                            start_go = 1'b1;
                        end
                    end
                end
                A_LEN: begin
                    if (busy_q) begin
                        err_d = 1'b1;
                    end else begin
                        len_d = wdata[PTR_W:0];
                    end
                end
                default: ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (start_go) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                mult_w_d = w_mem[idx_q];
                mult_x_d = x_mem[idx_q];
                state_d  = MAC;
            end
            MAC: begin
                acc_d = acc_q + mult_out;
                if ({1'b0, idx_q} == len_q - ONE_P) begin
                    state_d = ACT;
                end else begin
                    idx_d   = idx_q + ONE_I;
                    state_d = FETCH;
                end
            end
            ACT: begin
                result_d = acti_out;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd) begin
            case (addr)
                A_RESULT: rdata_d = result_q;
                A_LEN:    rdata_d = DATA_W'(len_q);
                A_STATUS: rdata_d = status;
                default:  rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            w_ptr_q  <= '0;
            x_ptr_q  <= '0;
            len_q    <= DEPTH_P;
            idx_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            mult_w_q <= '0;
            mult_x_q <= '0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            w_ptr_q  <= w_ptr_d;
            x_ptr_q  <= x_ptr_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            mult_w_q <= mult_w_d;
            mult_x_q <= mult_x_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Vector buffers keep their contents across reset and CLEAR.
    always_ff @(posedge clk) begin
        if (w_we) w_mem[w_ptr_q[PTR_W-1:0]] <= wdata;
        if (x_we) x_mem[x_ptr_q[PTR_W-1:0]] <= wdata;
    end

endmodule

// File: tb/tb_npu_mac_sequencer.sv
// Directed bench for npu_mac_sequencer with MULT as low-32 signed product and ACTI as ReLU.
module tb_npu_mac_sequencer;

    localparam logic [2:0] A_WDATA  = 3'd0;
    localparam logic [2:0] A_XDATA  = 3'd1;
    localparam logic [2:0] A_RESULT = 3'd2;
    localparam logic [2:0] A_CTRL   = 3'd3;
    localparam logic [2:0] A_LEN    = 3'd4;
    localparam logic [2:0] A_STATUS = 3'd5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        cs = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] mult_w, mult_x, mult_out, acti_in, acti_out;
    logic signed [63:0] prod;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    npu_mac_sequencer #(.DEPTH(16), .PTR_W(4), .DATA_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .cs       (cs),
        .read     (read),
        .write    (write),
        .mult_w   (mult_w),
        .mult_x   (mult_x),
        .mult_out (mult_out),
        .acti_in  (acti_in),
        .acti_out (acti_out)
    );

    always #5 clk = ~clk;

    assign prod     = $signed(mult_w) * $signed(mult_x);
    assign mult_out = prod[31:0];
    assign acti_out = acti_in[31] ? 32'h0 : acti_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] st_word(input int wp, input int xp,
                                            input logic b, input logic d, input logic e);
        logic [31:0] s;
        s        = '0;
        s[0]     = b;
        s[1]     = d;
        s[2]     = e;
        s[15:8]  = 8'(wp);
        s[23:16] = 8'(xp);
        return s;
    endfunction

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; write = 1'b1; addr = a; wdata = d;
        @(posedge clk);
        #1;
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; read = 1'b1; addr = a;
        @(posedge clk);
        #1;
        cs = 1'b0; read = 1'b0;
        d = rdata;
    endtask

    task automatic load_basic();
        bus_write(A_CTRL, 32'h2);
        for (int i = 0; i < 4; i++) bus_write(A_WDATA, 32'(i + 1));
        for (int i = 0; i < 4; i++) bus_write(A_XDATA, 32'(i + 5));
        bus_write(A_LEN, 32'd4);
    endtask

    // Polls STATUS until busy drops or the budget expires; caller checks the returned word.
    task automatic wait_idle(output logic [31:0] s);
        for (int i = 0; i < 60; i++) begin
            bus_read(A_STATUS, s);
            if (!s[0]) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s;

        #12;
        check_eq("rst_rdata", rdata, 32'h0);
        check_eq("rst_mult_w", mult_w, 32'h0);
        check_eq("rst_mult_x", mult_x, 32'h0);
        check_eq("rst_acti_in", acti_in, 32'h0);
        #5 rst = 1'b0;
        bus_read(A_STATUS, s); check_eq("rst_status", s, 32'h0);
        bus_read(A_LEN, s);    check_eq("rst_len", s, 32'd16);
        bus_read(A_RESULT, s); check_eq("rst_result", s, 32'h0);

        // Basic 4-element dot product: 1*5+2*6+3*7+4*8 = 70, done after E0+9
        load_basic();
        bus_write(A_CTRL, 32'h1);
        for (int k = 1; k <= 10; k++) begin
            bus_read(A_STATUS, s);
            check_eq($sformatf("basic_status_c%0d", k), s,
                     (k < 10) ? st_word(4, 4, 1'b1, 1'b0, 1'b0) : st_word(4, 4, 1'b0, 1'b1, 1'b0));
        end
        bus_read(A_RESULT, s); check_eq("basic_result", s, 32'd70);

        // Negative sum clamped by ReLU, LEN=1 finishes after E0+3
        bus_write(A_CTRL, 32'h2);
        bus_write(A_WDATA, 32'hFFFF_FFFD);
        bus_write(A_XDATA, 32'd2);
        bus_write(A_LEN, 32'd1);
        bus_write(A_CTRL, 32'h1);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("clamp_acti_in_act", acti_in, 32'hFFFF_FFFA);
        bus_read(A_STATUS, s); check_eq("clamp_status_e2", s, st_word(1, 1, 1'b1, 1'b0, 1'b0));
        bus_read(A_STATUS, s); check_eq("clamp_status_e3", s, st_word(1, 1, 1'b0, 1'b1, 1'b0));
        bus_read(A_RESULT, s); check_eq("clamp_result", s, 32'h0);

        // Accumulator wraps: 0x7FFFFFFF + 0x7FFFFFFF = 0xFFFFFFFE
        bus_write(A_CTRL, 32'h2);
        bus_write(A_WDATA, 32'h7FFF_FFFF);
        bus_write(A_WDATA, 32'h7FFF_FFFF);
        bus_write(A_XDATA, 32'd1);
        bus_write(A_XDATA, 32'd1);
        bus_write(A_LEN, 32'd2);
        bus_write(A_CTRL, 32'h1);
        wait_idle(s);          check_eq("wrap_status", s, st_word(2, 2, 1'b0, 1'b1, 1'b0));
        check_eq("wrap_acc", acti_in, 32'hFFFF_FFFE);
        bus_read(A_RESULT, s); check_eq("wrap_result", s, 32'h0);

        // START with LEN=0
        bus_write(A_CTRL, 32'h2);
        bus_write(A_LEN, 32'd0);
        bus_write(A_CTRL, 32'h1);
        bus_read(A_STATUS, s); check_eq("len0_status", s, st_word(0, 0, 1'b0, 1'b0, 1'b1));
        bus_write(A_CTRL, 32'h2);

        // START with LEN=17
        bus_write(A_LEN, 32'd17);
        bus_read(A_LEN, s);    check_eq("len17_readback", s, 32'd17);
        bus_write(A_CTRL, 32'h1);
        bus_read(A_STATUS, s); check_eq("len17_status", s, st_word(0, 0, 1'b0, 1'b0, 1'b1));
        bus_write(A_CTRL, 32'h2);
        bus_read(A_STATUS, s); check_eq("clear_status", s, 32'h0);

        // W_DATA write and START while busy must not disturb the run
        load_basic();
        bus_write(A_CTRL, 32'h1);
        bus_write(A_WDATA, 32'd99);
        bus_write(A_CTRL, 32'h1);
        wait_idle(s);          check_eq("busy_err_status", s, st_word(4, 4, 1'b0, 1'b1, 1'b1));
        bus_read(A_RESULT, s); check_eq("busy_err_result", s, 32'd70);
        bus_write(A_CTRL, 32'h2);

        // 17 W writes: pointer saturates at 16, err set
        for (int i = 0; i < 17; i++) bus_write(A_WDATA, 32'(100 + i));
        bus_read(A_STATUS, s); check_eq("wsat_status", s, st_word(16, 0, 1'b0, 1'b0, 1'b1));
        bus_write(A_CTRL, 32'h2);

        // Asynchronous reset while in MAC
        load_basic();
        bus_write(A_CTRL, 32'h1);
        @(posedge clk);
        #2;
        check_eq("mid_mult_w_pre", mult_w, 32'd1);
        check_eq("mid_mult_x_pre", mult_x, 32'd5);
        rst = 1'b1;
        #1;
        check_eq("mid_rdata", rdata, 32'h0);
        check_eq("mid_mult_w", mult_w, 32'h0);
        check_eq("mid_mult_x", mult_x, 32'h0);
        check_eq("mid_acti_in", acti_in, 32'h0);
        #10 rst = 1'b0;
        bus_read(A_STATUS, s); check_eq("mid_status", s, 32'h0);
        bus_read(A_LEN, s);    check_eq("mid_len", s, 32'd16);

        // Buffers survive reset; CLEAR+START in one write clears then starts
        bus_write(A_LEN, 32'd4);
        bus_write(A_CTRL, 32'h3);
        wait_idle(s);          check_eq("rerun_status", s, st_word(0, 0, 1'b0, 1'b1, 1'b0));
        bus_read(A_RESULT, s); check_eq("rerun_result", s, 32'd70);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
